// File: rtl/align_add_stage_if.sv
// Handshake and result bus for align_add_stage: operand pair in, aligned
// significand sum/difference out. The block drives the slave side.
interface align_add_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aligned_result;
  logic        carry_out;
  logic        sticky;
  logic [7:0]  exponent_out;
  logic        aligned_sign;
  logic [7:0]  flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, aligned_result, carry_out, sticky,
           exponent_out, aligned_sign, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, aligned_result, carry_out, sticky,
           exponent_out, aligned_sign, flags
  );
endinterface

// File: rtl/align_add_stage.sv
// FP single-precision align/add stage: orders operands by magnitude, aligns the
// smaller significand and adds/subtracts. FPADD_FAST_ALIGN_EN selects a one-shot
// barrel shift instead of the 1-bit-per-cycle ALIGN loop.
module align_add_stage (
  input  logic               clk,
  input  logic               reset,
  align_add_stage_if.slave   io
);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] l_sig_q, l_sig_d, s_sig_q, s_sig_d, res_q, res_d;
  logic [7:0]  l_exp_q, l_exp_d, exp_q, exp_d, flags_q, flags_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        l_sign_q, l_sign_d, s_sign_q, s_sign_d;
  logic        sticky_q, sticky_d, carry_q, carry_d, sign_q, sign_d;
  logic        special_q, special_d;

  // operand unpack (only meaningful in IDLE)
  logic [7:0]  a_exp, b_exp, a_eexp, b_eexp, exp_diff;
  logic [22:0] a_frac, b_frac;
  logic [31:0] a_sig, b_sig;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub, a_big;
  logic [7:0]  acc_flags;
  logic [5:0]  acc_cnt;

  always_comb begin
    a_exp    = io.a[30:23];
    b_exp    = io.b[30:23];
    a_frac   = io.a[22:0];
    b_frac   = io.b[22:0];
    a_nan    = (&a_exp) && (|a_frac);
    b_nan    = (&b_exp) && (|b_frac);
    a_inf    = (&a_exp) && !(|a_frac);
    b_inf    = (&b_exp) && !(|b_frac);
    a_zero   = !(|a_exp) && !(|a_frac);
    b_zero   = !(|b_exp) && !(|b_frac);
    a_sub    = !(|a_exp) && (|a_frac);
    b_sub    = !(|b_exp) && (|b_frac);
    a_sig    = {|a_exp, a_frac, 8'h00};
    b_sig    = {|b_exp, b_frac, 8'h00};
    a_eexp   = (a_exp == 8'd0) ? 8'd1 : a_exp;
    b_eexp   = (b_exp == 8'd0) ? 8'd1 : b_exp;
    a_big    = io.a[30:0] >= io.b[30:0];
    exp_diff = a_big ? (a_eexp - b_eexp) : (b_eexp - a_eexp);
    acc_cnt  = (exp_diff > 8'd32) ? 6'd32 : exp_diff[5:0];
    acc_flags = {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub};
  end

  // aligned smaller operand as seen by the ADD cycle
  logic [31:0] s_al;
  logic        st_al;
`ifdef FPADD_FAST_ALIGN_EN
  logic [63:0] shift_w;
  always_comb begin
    shift_w = {s_sig_q, 32'h0} >> cnt_q;
    s_al    = shift_w[63:32];
    st_al   = |shift_w[31:0];
  end
`else
  always_comb begin
    s_al  = s_sig_q;
    st_al = sticky_q;
  end
`endif

  logic [32:0] sum33;
  logic [31:0] add_res;
  logic        add_carry, cancel;
  always_comb begin
    sum33 = {1'b0, l_sig_q} + {1'b0, s_al};
    if (l_sign_q == s_sign_q) begin
      add_res   = sum33[31:0];
      add_carry = sum33[32];
    end else begin
      add_res   = l_sig_q - s_al - {31'b0, st_al};
      add_carry = 1'b0;
    end
    cancel = (add_res == 32'd0) && !add_carry && !st_al;
  end

  always_comb begin
    state_d   = state_q;
    l_sig_d   = l_sig_q;
    s_sig_d   = s_sig_q;
    l_exp_d   = l_exp_q;
    l_sign_d  = l_sign_q;
    s_sign_d  = s_sign_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    special_d = special_q;
    flags_d   = flags_q;
    res_d     = res_q;
    carry_d   = carry_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        l_sig_d   = a_big ? a_sig : b_sig;
        s_sig_d   = a_big ? b_sig : a_sig;
        l_exp_d   = a_big ? a_eexp : b_eexp;
        l_sign_d  = a_big ? io.a[31] : io.b[31];
        s_sign_d  = a_big ? io.b[31] : io.a[31];
        cnt_d     = acc_cnt;
        sticky_d  = 1'b0;
        flags_d   = acc_flags;
        special_d = |acc_flags[7:2];
        // special operands still pass through ADD so latency stays at 2
`ifdef FPADD_FAST_ALIGN_EN
        state_d = ADD;
`else
        state_d = (special_d || acc_cnt == 6'd0) ? ADD : ALIGN;
`endif
      end
      ALIGN: begin
        s_sig_d  = s_sig_q >> 1;
        sticky_d = sticky_q | s_sig_q[0];
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = ADD;
      end
      ADD: begin
        if (special_q) begin
          res_d    = 32'd0;
          carry_d  = 1'b0;
          sticky_d = 1'b0;
          exp_d    = 8'd0;
          sign_d   = 1'b0;
        end else begin
          res_d    = add_res;
          carry_d  = add_carry;
          sticky_d = st_al;
          exp_d    = l_exp_q;
          sign_d   = l_sign_q & ~cancel;
        end
        state_d = HOLD;
      end
      HOLD: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      l_sig_q   <= '0;
      s_sig_q   <= '0;
      l_exp_q   <= '0;
      l_sign_q  <= 1'b0;
      s_sign_q  <= 1'b0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      special_q <= 1'b0;
      flags_q   <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      l_sig_q   <= l_sig_d;
      s_sig_q   <= s_sig_d;
      l_exp_q   <= l_exp_d;
      l_sign_q  <= l_sign_d;
      s_sign_q  <= s_sign_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      special_q <= special_d;
      flags_q   <= flags_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
    end
  end

  assign io.in_ready       = (state_q == IDLE);
  assign io.out_valid      = (state_q == HOLD);
  assign io.aligned_result = res_q;
  assign io.carry_out      = carry_q;
  assign io.sticky         = sticky_q;
  assign io.exponent_out   = exp_q;
  assign io.aligned_sign   = sign_q;
  assign io.flags          = flags_q;

endmodule

// File: tb/tb_align_add_stage.sv
// Scoreboard bench for align_add_stage: directed cases plus random operand pairs,
// expected results queued at accept and compared when out_valid appears.
module tb_align_add_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  align_add_stage_if bus();
  align_add_stage dut (.clk(clk), .reset(reset), .io(bus));

`ifdef FPADD_FAST_ALIGN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        carry;
    logic        sticky;
    logic [7:0]  exp;
    logic        sign;
    logic [7:0]  flags;
    int          lat;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic carry, input logic sticky,
                              input logic [7:0] exp, input logic sign, input logic [7:0] flags,
                              input int lat);
    exp_t e;
    e.res = res; e.carry = carry; e.sticky = sticky; e.exp = exp;
    e.sign = sign; e.flags = flags; e.lat = lat;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [7:0]  ea, eb, xa, xb, d;
    logic [31:0] ga, gb, gl, gs, shs;
    logic [32:0] sum;
    logic        sl, ss, st;
    int          cnt;
    ea = a[30:23]; eb = b[30:23];
    e.flags = {ea == 8'hFF && a[22:0] != 0, eb == 8'hFF && b[22:0] != 0,
               ea == 8'hFF && a[22:0] == 0, eb == 8'hFF && b[22:0] == 0,
               ea == 8'h00 && a[22:0] == 0, eb == 8'h00 && b[22:0] == 0,
               ea == 8'h00 && a[22:0] != 0, eb == 8'h00 && b[22:0] != 0};
    if (e.flags[7:2] != 6'd0) begin
      e.res = 0; e.carry = 0; e.sticky = 0; e.exp = 0; e.sign = 0; e.lat = 2;
      return e;
    end
    xa = (ea == 0) ? 8'd1 : ea;
    xb = (eb == 0) ? 8'd1 : eb;
    ga = {ea != 0, a[22:0], 8'h00};
    gb = {eb != 0, b[22:0], 8'h00};
    if (a[30:0] >= b[30:0]) begin
      gl = ga; gs = gb; sl = a[31]; ss = b[31]; e.exp = xa; d = xa - xb;
    end else begin
      gl = gb; gs = ga; sl = b[31]; ss = a[31]; e.exp = xb; d = xb - xa;
    end
    cnt = (d > 32) ? 32 : int'(d);
    shs = (cnt >= 32) ? 32'd0 : (gs >> cnt);
    st  = (cnt >= 32) ? (gs != 0) : ((64'(gs) & ((64'd1 << cnt) - 64'd1)) != 0);
    if (sl == ss) begin
      sum = 33'(gl) + 33'(shs);
      e.res = sum[31:0]; e.carry = sum[32];
    end else begin
      e.res = gl - shs - 32'(st); e.carry = 1'b0;
    end
    e.sticky = st;
    e.sign = (e.res == 0 && !e.carry && !st) ? 1'b0 : sl;
    e.lat = FAST ? 2 : 2 + cnt;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_res"},   64'(bus.aligned_result), 64'(e.res));
    chk({tag, "_carry"}, 64'(bus.carry_out),      64'(e.carry));
    chk({tag, "_stky"},  64'(bus.sticky),         64'(e.sticky));
    chk({tag, "_exp"},   64'(bus.exponent_out),   64'(e.exp));
    chk({tag, "_sign"},  64'(bus.aligned_sign),   64'(e.sign));
    chk({tag, "_flags"}, 64'(bus.flags),          64'(e.flags));
  endtask

  // Called at a negedge; returns at a negedge with the stage back in IDLE.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input exp_t e, input int hold, input bit poke);
    int   w, lat;
    exp_t ex;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin chk({tag, "_rdy_timeout"}, 64'(0), 64'(1)); return; end
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk);
    sbq.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!bus.out_valid) begin
      chk({tag, "_out_timeout"}, 64'(0), 64'(1));
      sbq.delete();
      return;
    end
    ex = sbq.pop_front();
    chk({tag, "_lat"}, 64'(lat), 64'(ex.lat));
    check_out(tag, ex);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom; end
      @(negedge clk);
      chk({tag, "_hold_vld"}, 64'(bus.out_valid), 64'(1));
      chk({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'(0));
      check_out({tag, "_hold"}, ex);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_rel_vld"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_rel_rdy"}, 64'(bus.in_ready), 64'(1));
  endtask

  function automatic logic [31:0] rnd_fp();
    int          r;
    logic [7:0]  e;
    logic [22:0] f;
    r = $urandom_range(0, 11);
    if (r == 0)      e = 8'hFF;
    else if (r == 1) e = 8'h00;
    else             e = 8'(8'h50 + $urandom_range(0, 80));
    f = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy",   64'(bus.in_ready),       64'(1));
    chk("rst_vld",   64'(bus.out_valid),      64'(0));
    chk("rst_res",   64'(bus.aligned_result), 64'(0));
    chk("rst_flags", 64'(bus.flags),          64'(0));
    reset = 1'b0;

    run("one_plus_one", 32'h3F800000, 32'h3F800000,
        mk(32'h00000000, 1, 0, 8'h7F, 0, 8'h00, 2), 0, 0);
    run("one_plus_half", 32'h3F800000, 32'h3F000000,
        mk(32'hC0000000, 0, 0, 8'h7F, 0, 8'h00, FAST ? 2 : 3), 1, 0);
    run("cancel", 32'h3F800000, 32'hBF800000,
        mk(32'h00000000, 0, 0, 8'h7F, 0, 8'h00, 2), 0, 0);
    run("far_align", 32'h3F800000, 32'h00800000,
        mk(32'h80000000, 0, 1, 8'h7F, 0, 8'h00, FAST ? 2 : 34), 0, 0);
    run("nan_hold", 32'h7FC00000, 32'h3F800000,
        mk(32'h00000000, 0, 0, 8'h00, 0, 8'h80, 2), 5, 1);

    // reset in the middle of the far-align transaction
    bus.a = 32'h3F800000; bus.b = 32'h00800000; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_vld",   64'(bus.out_valid),      64'(0));
    chk("midrst_rdy",   64'(bus.in_ready),       64'(1));
    chk("midrst_res",   64'(bus.aligned_result), 64'(0));
    chk("midrst_stky",  64'(bus.sticky),         64'(0));
    chk("midrst_flags", 64'(bus.flags),          64'(0));
    @(negedge clk);
    reset = 1'b0;
    run("post_rst", 32'h3F800000, 32'h3F800000,
        mk(32'h00000000, 1, 0, 8'h7F, 0, 8'h00, 2), 0, 0);

    // mirrored and subnormal directed pairs through the model
    run("mirror", 32'h3F000000, 32'hBF800000, model(32'h3F000000, 32'hBF800000), 0, 0);
    run("subs",   32'h00400001, 32'h80200003, model(32'h00400001, 32'h80200003), 0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = rnd_fp();
      rb = ($urandom_range(0, 7) == 0) ? {~ra[31], ra[30:0]} : rnd_fp();
      run("rnd", ra, rb, model(ra, rb), $urandom_range(0, 2), 1'($urandom));
    end

    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
